operand_fetch: RTL



---
 rtl/alu_pkg.sv | 57 +++++
 rtl/operand_fetch_if.sv | 29 ++
 rtl/operand_fetch_regfile.sv | 39 +++
 rtl/operand_fetch.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-pipeline definitions: widths, instruction field layout, opcodes and payload structs.
package alu_pkg;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OP_MSB      = 31;
  localparam int unsigned OP_LSB      = 29;
  localparam int unsigned USE_IMM_BIT = 28;
  localparam int unsigned RD_MSB      = 27;
  localparam int unsigned RD_LSB      = 25;
  localparam int unsigned RS1_MSB     = 24;
  localparam int unsigned RS1_LSB     = 22;
  localparam int unsigned RS2_MSB     = 21;
  localparam int unsigned RS2_LSB     = 19;
  localparam int unsigned IMM_MSB     = 15;
  localparam int unsigned IMM_LSB     = 0;
  localparam int unsigned RSVD_W      = RS2_LSB - IMM_MSB - 1;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_NAND = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5
  } alu_op_e;

  // Lowest opcode that raises illegal_op.
  localparam logic [OP_W-1:0] ALU_ILLEGAL_MIN = 3'd6;

  typedef struct packed {
    logic [OP_W-1:0]   aluop;
    logic              use_imm;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [RSVD_W-1:0] rsvd;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   aluop;
    logic [REG_W-1:0]  rd;
  } fetch_out_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: instruction handshake in, operand handshake out, writeback return path.
interface operand_fetch_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [OP_W-1:0]      aluop;
  logic [REG_W-1:0]     rd;
  logic                 wb_en;
  logic [REG_W-1:0]     wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 illegal_op;

  modport master (
    output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, a, b, aluop, rd, illegal_op
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, a, b, aluop, rd, illegal_op
  );

endinterface

// File: rtl/operand_fetch_regfile.sv
// 8x32 register file, two async read ports with write-first bypass, one sync write port, r0 reads zero.
module regfile_2r1w
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  i_raddr_a,
  input  logic [REG_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a_c,
  output logic [DATA_W-1:0] o_rdata_b_c,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle writeback is forwarded so an instruction waiting on it can issue immediately.
  always_comb begin
    o_rdata_a_c = r_mem[i_raddr_a];
    o_rdata_b_c = r_mem[i_raddr_b];
    if (i_raddr_a == '0)                     o_rdata_a_c = '0;
    else if (w_wr && (i_waddr == i_raddr_a)) o_rdata_a_c = i_wdata;
    if (i_raddr_b == '0)                     o_rdata_b_c = '0;
    else if (w_wr && (i_waddr == i_raddr_b)) o_rdata_b_c = i_wdata;
  end

endmodule

// File: rtl/operand_fetch.sv
// ALU operand-fetch stage: pending-write scoreboard, hazard stall, operand read and output register.
module operand_fetch
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.slave  io_bus
);

  instr_t            w_instr;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic [NREGS-1:0]  r_pending;
  logic [NREGS-1:0]  w_pending_nxt;
  logic [NREGS-1:0]  w_pend;
  logic              w_hz;
  logic              w_in_ready_c;
  logic              w_accept;
  logic              w_wb_live;
  fetch_out_t        w_out_nxt;
  fetch_out_t        r_out;
  logic              r_out_valid;
  logic              r_illegal;
  logic              w_unused_rsvd;

  assign w_instr       = instr_t'(io_bus.instr);
  assign w_unused_rsvd = ^w_instr.rsvd;
  assign w_wb_live     = io_bus.wb_en && (io_bus.wb_addr != '0);

  regfile_2r1w u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_raddr_a   (w_instr.rs1),
    .i_raddr_b   (w_instr.rs2),
    .o_rdata_a_c (w_rs1_data),
    .o_rdata_b_c (w_rs2_data),
    .i_we        (io_bus.wb_en),
    .i_waddr     (io_bus.wb_addr),
    .i_wdata     (io_bus.wb_data)
  );

  // A register stops being pending in the very cycle its writeback arrives.
  always_comb begin
    w_pend = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      w_pend[i] = r_pending[i] && !(io_bus.wb_en && (io_bus.wb_addr == REG_W'(i)));
    end
  end

  assign w_hz = w_pend[w_instr.rs1] | (!w_instr.use_imm & w_pend[w_instr.rs2]) | w_pend[w_instr.rd];
  assign w_in_ready_c = !w_hz && (!r_out_valid || io_bus.out_ready);
  assign w_accept     = io_bus.in_valid && w_in_ready_c;

  always_comb begin
    w_out_nxt.a     = w_rs1_data;
    w_out_nxt.b     = w_instr.use_imm ? sext_imm(w_instr.imm) : w_rs2_data;
    w_out_nxt.aluop = w_instr.aluop;
    w_out_nxt.rd    = w_instr.rd;
  end

  // Clear on writeback first so a new writer of the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_live) w_pending_nxt[io_bus.wb_addr] = 1'b0;
    if (w_accept && (w_instr.rd != '0)) w_pending_nxt[w_instr.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_out       <= w_out_nxt;
        r_out_valid <= 1'b1;
        if (w_instr.aluop >= ALU_ILLEGAL_MIN) r_illegal <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready   = w_in_ready_c;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.a          = r_out.a;
  assign io_bus.b          = r_out.b;
  assign io_bus.aluop      = r_out.aluop;
  assign io_bus.rd         = r_out.rd;
  assign io_bus.illegal_op = r_illegal;

endmodule
